// File: rtl/vs_div_arbiter.sv
// Shared signed Q-format divider for the vertex-shader lanes: round-robin grant,
// bit-serial restoring division, fixed latency, saturating result.
//   state  | meaning
//   S_IDLE | arbitrate, accept one lane's operands
//   S_LOAD | record sign / zero-divisor, form magnitudes
//   S_DIV  | one quotient bit per cycle, FIXED_WIDTH+FRAC_BITS cycles
//   S_FIX  | saturate / negate into the response register
//   S_RESP | one-cycle resp_valid pulse to the granted lane
module vs_div_arbiter #(
  parameter int FIXED_WIDTH = 16,
  parameter int FRAC_BITS   = 8,
  parameter int NUM_REQ     = 4,
  parameter int REQ_BIT     = 2
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ*FIXED_WIDTH-1:0] req_dividend,
  input  logic [NUM_REQ*FIXED_WIDTH-1:0] req_divisor,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic [NUM_REQ-1:0]             resp_valid,
  output logic [REQ_BIT-1:0]             resp_tag,
  output logic [FIXED_WIDTH-1:0]         resp_quotient,
  output logic                           resp_div_by_zero,
  output logic                           busy
);

  localparam int N  = FIXED_WIDTH + FRAC_BITS;
  localparam int CW = $clog2(N);
  localparam logic [FIXED_WIDTH-1:0] ONE     = {{(FIXED_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [FIXED_WIDTH-1:0] SAT_POS = {1'b0, {(FIXED_WIDTH-1){1'b1}}};
  localparam logic [FIXED_WIDTH-1:0] SAT_NEG = {1'b1, {(FIXED_WIDTH-1){1'b0}}};
  localparam logic [N-1:0] MAX_POS = {{(FRAC_BITS+1){1'b0}}, {(FIXED_WIDTH-1){1'b1}}};
  localparam logic [N-1:0] MAX_NEG = {{FRAC_BITS{1'b0}}, 1'b1, {(FIXED_WIDTH-1){1'b0}}};
  localparam logic [NUM_REQ-1:0] LANE0 = {{(NUM_REQ-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_DIV, S_FIX, S_RESP} state_t;

  state_t state_q, state_d;
  logic [REQ_BIT-1:0]     rr_ptr_q, rr_ptr_d, tag_q, tag_d;
  logic [FIXED_WIDTH-1:0] opa_q, opa_d, opb_q, opb_d, den_q, den_d;
  logic                   neg_q, neg_d, a_neg_q, a_neg_d, dz_q, dz_d;
  logic [N-1:0]           num_q, num_d, quo_q, quo_d;
  logic [FIXED_WIDTH:0]   rem_q, rem_d, trial;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [FIXED_WIDTH-1:0] quot_q, quot_d, fix_result;
  logic                   flag_q, flag_d;
  logic                   grant_found, handshake;
  logic [REQ_BIT-1:0]     grant_idx;

  function automatic logic [FIXED_WIDTH-1:0] mag(input logic [FIXED_WIDTH-1:0] v);
    return v[FIXED_WIDTH-1] ? (~v + ONE) : v;
  endfunction

  // First requester at or above rr_ptr, wrapping.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!grant_found && req_valid[(int'(rr_ptr_q) + i) % NUM_REQ]) begin
        grant_found = 1'b1;
        grant_idx   = REQ_BIT'((int'(rr_ptr_q) + i) % NUM_REQ);
      end
    end
  end

  assign handshake = (state_q == S_IDLE) && grant_found && !reset;

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (handshake) state_d = S_LOAD;
      S_LOAD:  state_d = S_DIV;
      S_DIV:   if (cnt_q == '0) state_d = S_FIX;
      S_FIX:   state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready  = handshake ? (LANE0 << grant_idx) : '0;
    resp_valid = (state_q == S_RESP) ? (LANE0 << tag_q) : '0;
    busy       = (state_q != S_IDLE);
  end

  assign resp_tag         = tag_q;
  assign resp_quotient    = quot_q;
  assign resp_div_by_zero = flag_q;
  assign trial            = {rem_q[FIXED_WIDTH-1:0], num_q[N-1]};

  always_comb begin
    if (dz_q)                          fix_result = a_neg_q ? SAT_NEG : SAT_POS;
    else if (!neg_q && quo_q > MAX_POS) fix_result = SAT_POS;
    else if (neg_q && quo_q > MAX_NEG)  fix_result = SAT_NEG;
    else if (neg_q)                     fix_result = ~quo_q[FIXED_WIDTH-1:0] + ONE;
    else                                fix_result = quo_q[FIXED_WIDTH-1:0];
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    tag_d    = tag_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    den_d    = den_q;
    neg_d    = neg_q;
    a_neg_d  = a_neg_q;
    dz_d     = dz_q;
    num_d    = num_q;
    quo_d    = quo_q;
    rem_d    = rem_q;
    cnt_d    = cnt_q;
    quot_d   = quot_q;
    flag_d   = flag_q;
    case (state_q)
      S_IDLE: if (handshake) begin
        tag_d    = grant_idx;
        opa_d    = req_dividend[int'(grant_idx)*FIXED_WIDTH +: FIXED_WIDTH];
        opb_d    = req_divisor[int'(grant_idx)*FIXED_WIDTH +: FIXED_WIDTH];
        rr_ptr_d = REQ_BIT'((int'(grant_idx) + 1) % NUM_REQ);
      end
      S_LOAD: begin
        neg_d   = opa_q[FIXED_WIDTH-1] ^ opb_q[FIXED_WIDTH-1];
        a_neg_d = opa_q[FIXED_WIDTH-1];
        dz_d    = (opb_q == '0);
        den_d   = mag(opb_q);
        num_d   = {mag(opa_q), {FRAC_BITS{1'b0}}};
        rem_d   = '0;
        quo_d   = '0;
        cnt_d   = CW'(N - 1);
      end
      S_DIV: begin
        num_d = {num_q[N-2:0], 1'b0};
        cnt_d = cnt_q - CW'(1);
        if (trial >= {1'b0, den_q}) begin
          rem_d = trial - {1'b0, den_q};
          quo_d = {quo_q[N-2:0], 1'b1};
        end else begin
          rem_d = trial;
          quo_d = {quo_q[N-2:0], 1'b0};
        end
      end
      S_FIX: begin
        quot_d = fix_result;
        flag_d = dz_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr_q <= '0;
      tag_q    <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      den_q    <= '0;
      neg_q    <= 1'b0;
      a_neg_q  <= 1'b0;
      dz_q     <= 1'b0;
      num_q    <= '0;
      quo_q    <= '0;
      rem_q    <= '0;
      cnt_q    <= '0;
      quot_q   <= '0;
      flag_q   <= 1'b0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      tag_q    <= tag_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      den_q    <= den_d;
      neg_q    <= neg_d;
      a_neg_q  <= a_neg_d;
      dz_q     <= dz_d;
      num_q    <= num_d;
      quo_q    <= quo_d;
      rem_q    <= rem_d;
      cnt_q    <= cnt_d;
      quot_q   <= quot_d;
      flag_q   <= flag_d;
    end
  end

endmodule

// File: tb/tb_vs_div_arbiter.sv
// Directed bench for vs_div_arbiter: table of single-lane divisions plus
// round-robin, dropped-request and reset-mid-division sequences.
module tb_vs_div_arbiter;
  localparam int LAT = 27;
  localparam int PERIOD = 28;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req_valid;
  logic [63:0] req_dividend, req_divisor;
  logic [3:0]  req_ready, resp_valid;
  logic [1:0]  resp_tag;
  logic [15:0] resp_quotient;
  logic        resp_div_by_zero, busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  vs_div_arbiter dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_dividend(req_dividend), .req_divisor(req_divisor),
    .req_ready(req_ready), .resp_valid(resp_valid), .resp_tag(resp_tag),
    .resp_quotient(resp_quotient), .resp_div_by_zero(resp_div_by_zero), .busy(busy)
  );

  typedef struct {
    int          lane;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] q;
    logic        dz;
  } vec_t;

  vec_t        vecs[12];
  logic [15:0] rr_a[4], rr_b[4], rr_q[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_lane(input int lane, input logic [15:0] a, input logic [15:0] b);
    req_dividend[lane*16 +: 16] = a;
    req_divisor[lane*16 +: 16]  = b;
  endtask

  // Checks the current sample first, so a grant in the driving cycle is seen.
  task automatic wait_grant(input int lane, output int gcyc, output int waited);
    logic [3:0] oh;
    bit seen;
    oh = 4'b0001 << lane;
    seen = 0;
    waited = 0;
    while (waited < 120) begin
      if (req_ready != 4'b0000) begin
        seen = 1;
        break;
      end
      @(negedge clk);
      waited++;
    end
    check($sformatf("grant_seen lane%0d", lane), 32'(seen), 32'd1);
    check($sformatf("grant_onehot lane%0d", lane), 32'(req_ready), 32'(oh));
    gcyc = cyc;
  endtask

  task automatic wait_resp(input int lane, input int gcyc, input logic [15:0] q,
                           input logic dz, input bit drop);
    logic [3:0] oh;
    bit seen, ready_while_busy;
    int n;
    oh = 4'b0001 << lane;
    seen = 0;
    ready_while_busy = 0;
    n = 0;
    while (n < 60) begin
      @(negedge clk);
      n++;
      if (drop && n == 1) begin
        req_valid = 4'b0000;
        check("busy_after_grant", 32'(busy), 32'd1);
      end
      if (req_ready != 4'b0000) ready_while_busy = 1;
      if (resp_valid != 4'b0000) begin
        seen = 1;
        break;
      end
    end
    check($sformatf("resp_seen lane%0d", lane), 32'(seen), 32'd1);
    check("ready_while_busy", 32'(ready_while_busy), 32'd0);
    check($sformatf("latency lane%0d", lane), 32'(cyc - gcyc), 32'(LAT));
    check($sformatf("resp_valid lane%0d", lane), 32'(resp_valid), 32'(oh));
    check($sformatf("resp_tag lane%0d", lane), 32'(resp_tag), 32'(lane));
    check($sformatf("quotient lane%0d", lane), 32'(resp_quotient), 32'(q));
    check($sformatf("div_by_zero lane%0d", lane), 32'(resp_div_by_zero), 32'(dz));
  endtask

  initial begin
    int g, prev_g, waited, pulses, busy_seen;
    int order_a[6];
    int order_b[4];

    vecs[0]  = '{0, 16'h0300, 16'h0200, 16'h0180, 1'b0};
    vecs[1]  = '{1, 16'hFD00, 16'h0200, 16'hFE80, 1'b0};
    vecs[2]  = '{2, 16'hFF00, 16'h0300, 16'hFFAB, 1'b0};
    vecs[3]  = '{3, 16'h8000, 16'hFF00, 16'h7FFF, 1'b0};
    vecs[4]  = '{0, 16'h0100, 16'h0000, 16'h7FFF, 1'b1};
    vecs[5]  = '{1, 16'hFF00, 16'h0000, 16'h8000, 1'b1};
    vecs[6]  = '{2, 16'h7F00, 16'h0080, 16'h7FFF, 1'b0};
    vecs[7]  = '{3, 16'h8100, 16'h0080, 16'h8000, 1'b0};
    vecs[8]  = '{0, 16'h0000, 16'hFF00, 16'h0000, 1'b0};
    vecs[9]  = '{1, 16'h8000, 16'h0100, 16'h8000, 1'b0};
    vecs[10] = '{2, 16'h7FFF, 16'h0100, 16'h7FFF, 1'b0};
    vecs[11] = '{3, 16'h0001, 16'h7FFF, 16'h0000, 1'b0};

    rr_a = '{16'h0300, 16'hFD00, 16'h0100, 16'h0600};
    rr_b = '{16'h0200, 16'h0200, 16'h0400, 16'hFE00};
    rr_q = '{16'h0180, 16'hFE80, 16'h0040, 16'hFD00};
    order_a = '{0, 1, 2, 3, 0, 1};
    order_b = '{0, 1, 3, 0};

    reset = 1'b1;
    req_valid = 4'b0000;
    req_dividend = '0;
    req_divisor = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_tag", 32'(resp_tag), 32'd0);
    check("rst_quotient", 32'(resp_quotient), 32'd0);
    check("rst_dz", 32'(resp_div_by_zero), 32'd0);
    req_valid = 4'b1111;
    #1;
    check("rst_ready_forced", 32'(req_ready), 32'd0);
    @(negedge clk);
    req_valid = 4'b0000;
    reset = 1'b0;

    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      drive_lane(vecs[i].lane, vecs[i].a, vecs[i].b);
      req_valid = 4'b0001 << vecs[i].lane;
      #1;
      wait_grant(vecs[i].lane, g, waited);
      check($sformatf("grant_same_cycle v%0d", i), 32'(waited), 32'd0);
      wait_resp(vecs[i].lane, g, vecs[i].q, vecs[i].dz, 1'b1);
      @(negedge clk);
      check($sformatf("pulse_end v%0d", i), 32'(resp_valid), 32'd0);
      check($sformatf("quot_hold v%0d", i), 32'(resp_quotient), 32'(vecs[i].q));
      check($sformatf("dz_hold v%0d", i), 32'(resp_div_by_zero), 32'(vecs[i].dz));
      check($sformatf("idle_after v%0d", i), 32'(busy), 32'd0);
    end

    // All lanes requesting continuously.
    @(negedge clk);
    reset = 1'b1;
    for (int l = 0; l < 4; l++) drive_lane(l, rr_a[l], rr_b[l]);
    req_valid = 4'b1111;
    #1;
    check("rr_ready_in_reset", 32'(req_ready), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    prev_g = 0;
    for (int k = 0; k < 6; k++) begin
      wait_grant(order_a[k], g, waited);
      if (k > 0) check($sformatf("rr_spacing %0d", k), 32'(g - prev_g), 32'(PERIOD));
      prev_g = g;
      wait_resp(order_a[k], g, rr_q[order_a[k]], 1'b0, 1'b0);
    end

    // Lane 2 withdrawn: it must be skipped.
    @(negedge clk);
    reset = 1'b1;
    req_valid = 4'b1011;
    @(negedge clk);
    reset = 1'b0;
    #1;
    for (int k = 0; k < 4; k++) begin
      wait_grant(order_b[k], g, waited);
      if (k > 0) check($sformatf("skip_spacing %0d", k), 32'(g - prev_g), 32'(PERIOD));
      prev_g = g;
      wait_resp(order_b[k], g, rr_q[order_b[k]], 1'b0, 1'b0);
    end

    // Reset lands mid-division.
    @(negedge clk);
    reset = 1'b1;
    req_valid = 4'b0000;
    @(negedge clk);
    reset = 1'b0;
    drive_lane(0, 16'h0300, 16'h0200);
    req_valid = 4'b0001;
    #1;
    wait_grant(0, g, waited);
    @(negedge clk);
    req_valid = 4'b0000;
    repeat (9) @(negedge clk);
    check("mid_busy_before", 32'(busy), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mid_busy_after", 32'(busy), 32'd0);
    check("mid_quot_cleared", 32'(resp_quotient), 32'd0);
    pulses = 0;
    busy_seen = 0;
    for (int c = 0; c < 35; c++) begin
      @(negedge clk);
      if (resp_valid != 4'b0000) pulses++;
      if (busy) busy_seen++;
    end
    check("mid_no_resp", 32'(pulses), 32'd0);
    check("mid_stays_idle", 32'(busy_seen), 32'd0);
    drive_lane(3, 16'h0600, 16'hFE00);
    req_valid = 4'b1000;
    #1;
    wait_grant(3, g, waited);
    check("wrap_grant_same_cycle", 32'(waited), 32'd0);
    wait_resp(3, g, 16'hFD00, 1'b0, 1'b1);

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
